flow_ctrl: RTL and testbench
============================

FLOW_CTRL -- requirements
Module: flow_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 20'h00000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter TRAP_VECTOR, default 20'h00010, the PC value loaded on TRAP.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, ports clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 op_valid  in  1  flow operation offered.
REQ-007 op_ready  out  1  block accepts an operation this cycle.
REQ-008 op  in  3  opcode: 0 TRAP, 1 NOP, 2 JMP, 3 JZ, 4 JS, 5 JZS, 6 LDSR, 7 XORSR.
REQ-009 operand  in  20  jump target, or status value in bits [2:0] for LDSR/XORSR.
REQ-010 flag_valid  in  1  ALU result flags are valid this cycle.
REQ-011 flag_zero, flag_sign, flag_carry  in  1 each  ALU flags, already resolved for half-word or full-word mode.
REQ-012 trap_clr  in  1  pulse that releases the trap state.
REQ-013 pc  out  20  current program counter.
REQ-014 status  out  3  status register {C,S,Z}: bit0 Z, bit1 S, bit2 C.
REQ-015 done  out  1  one-cycle pulse when an operation retires.
REQ-016 taken  out  1  valid with done; high when a jump or TRAP redirected the PC.
REQ-017 trapped  out  1  high while in the TRAP state.
REQ-018 epc  out  20  return PC captured on TRAP.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC, and TRAP.
REQ-020 op_ready SHALL be 1 only in IDLE.
REQ-021 An op is accepted when op_valid && op_ready; op and operand are latched, and the state moves IDLE->EXEC.
REQ-022 In EXEC the op retires: done=1, the PC and status update at that clock edge, and the state returns to IDLE. The exception is TRAP, which goes to TRAP. Throughput is one op per 2 cycles.
REQ-023 Branch conditions use the status value as it stands in EXEC, including any flag_valid update that arrived in the accept cycle: JZ if Z; JS if S; JZS if Z|S; JMP always.
REQ-024 Taken jump: pc <= operand and taken=1. Not taken, NOP, LDSR or XORSR: pc <= pc+1, wrapping 20'hFFFFF -> 20'h00000.
REQ-025 LDSR: status <= operand[2:0]. XORSR: status <= status ^ operand[2:0].
REQ-026 Whenever flag_valid=1 and no LDSR/XORSR is retiring, status <= {flag_carry, flag_sign, flag_zero}.
REQ-027 If flag_valid coincides with a retiring LDSR/XORSR, the LDSR/XORSR write wins.
REQ-028 TRAP retire: epc <= pc+1 (wrapping), pc <= TRAP_VECTOR, taken=1, trapped=1.
REQ-029 In TRAP, ops are not accepted. flag_valid still updates status.
REQ-030 trap_clr in TRAP moves the state to IDLE on the next edge, clearing trapped; pc is unchanged.
REQ-031 trap_clr outside TRAP SHALL be ignored.
REQ-032 op_valid without op_ready SHALL be ignored; operand changes in EXEC have no effect.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE, pc=RESET_PC, status=3'b000, epc=0, done=0, taken=0, trapped=0.
REQ-034 op_ready SHALL read 1 once rst_n is high.
REQ-035 Reset during EXEC or TRAP SHALL abandon the op with no done pulse.

Structure
REQ-036 Opcode constants, status bit indices, and the 20-bit word width SHALL live in the shared package cpu_pkg.
REQ-037 The status register, covering the flag latch and the LDSR/XORSR priority, SHALL be the sub-module status_reg. The FSM and PC logic stay in flow_ctrl.

Verification
REQ-038 Reset, then NOP x3 -> pc 0,1,2,3; one done per op, 2 cycles apart; taken=0.
REQ-039 flag_valid with Z=1, then JZ operand=20'h00ABC -> pc=20'h00ABC, taken=1. Repeat with Z=0 -> pc+1, taken=0.
REQ-040 pc=20'hFFFFF, NOP -> pc=20'h00000. pc=20'h00005, TRAP -> pc=20'h00010, epc=20'h00006, op_ready=0 until trap_clr.
REQ-041 LDSR 3'b101 retiring while flag_valid drives {1,1,1} -> status=3'b101. Then XORSR 3'b011 -> status=3'b110.
REQ-042 rst_n low mid-EXEC of JMP 20'h12345 -> pc=RESET_PC, no done, status=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the flow-control slice.
//   WORD_W       program counter / operand width
//   op_e         flow opcodes as presented on the op port
//   SR_Z/S/C     bit positions inside the 3-bit status register
//   state_e      flow_ctrl FSM states
//   pc_inc       PC increment, wraps naturally at the word width
package cpu_pkg;

  localparam int WORD_W = 20;
  localparam int SR_W   = 3;

  localparam int SR_Z = 0;
  localparam int SR_S = 1;
  localparam int SR_C = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    OP_TRAP  = 3'd0,
    OP_NOP   = 3'd1,
    OP_JMP   = 3'd2,
    OP_JZ    = 3'd3,
    OP_JS    = 3'd4,
    OP_JZS   = 3'd5,
    OP_LDSR  = 3'd6,
    OP_XORSR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/status_reg.sv
// status_reg: 3-bit {C,S,Z} status register.
//   clk, rst_n         clock, asynchronous active-low reset (clears status)
//   flag_valid         load ALU flags {carry,sign,zero} this cycle
//   flag_zero/sign/carry ALU flags
//   sr_wr              an LDSR/XORSR is retiring; overrides the flag load
//   sr_xor             1: status ^= sr_val, 0: status = sr_val
//   sr_val             value from the instruction operand
//   status             current register contents
module status_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flag_valid,
  input  logic            flag_zero,
  input  logic            flag_sign,
  input  logic            flag_carry,
  input  logic            sr_wr,
  input  logic            sr_xor,
  input  logic [SR_W-1:0] sr_val,
  output logic [SR_W-1:0] status
);

  logic [SR_W-1:0] status_q;
  logic [SR_W-1:0] status_d;
  logic [SR_W-1:0] flags_w;

  always_comb begin
    flags_w       = '0;
    flags_w[SR_Z] = flag_zero;
    flags_w[SR_S] = flag_sign;
    flags_w[SR_C] = flag_carry;
  end

  // An explicit status write from the instruction stream beats a
  // simultaneous ALU flag update.
  always_comb begin
    status_d = status_q;
    if (sr_wr) begin
      status_d = sr_xor ? (status_q ^ sr_val) : sr_val;
    end else if (flag_valid) begin
      status_d = flags_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status = status_q;

endmodule

// File: rtl/flow_ctrl.sv
// flow_ctrl: program-flow sequencer (jumps, traps, status writes).
//   clk, rst_n      clock, asynchronous active-low reset
//   op_valid/ready  operation handshake; ready only in IDLE
//   op, operand     opcode and jump target / status value
//   flag_valid, flag_zero/sign/carry  ALU flag update
//   trap_clr        leaves the TRAP state
//   pc, status, epc architectural state
//   done, taken     one-cycle retire pulse and redirect indication
//   trapped         high while in TRAP
// An accepted op spends one cycle in EXEC and retires on the next edge,
// giving one op every two cycles.
module flow_ctrl
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = 20'h00000,
  parameter logic [WORD_W-1:0] TRAP_VECTOR = 20'h00010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op,
  input  logic [WORD_W-1:0] operand,
  input  logic              flag_valid,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              trap_clr,
  output logic [WORD_W-1:0] pc,
  output logic [SR_W-1:0]   status,
  output logic              done,
  output logic              taken,
  output logic              trapped,
  output logic [WORD_W-1:0] epc
);

  state_e state_q, state_d;
  word_t  pc_q, pc_d;
  word_t  epc_q, epc_d;
  logic   done_q, done_d;
  logic   taken_q, taken_d;

  op_e    op_q;
  word_t  operand_q;

  logic   accept;
  logic   branch;
  logic   sr_wr;

  assign accept = op_valid && (state_q == ST_IDLE);

  // Instruction latch: data only, qualified by the handshake, so operand
  // changes after acceptance cannot affect the retiring op.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= op_e'(op);
      operand_q <= operand;
    end
  end

  // Branch decisions read the registered status, which already contains
  // any flag update that landed on the accept edge.
  always_comb begin
    branch = 1'b0;
    case (op_q)
      OP_JMP:  branch = 1'b1;
      OP_JZ:   branch = status[SR_Z];
      OP_JS:   branch = status[SR_S];
      OP_JZS:  branch = status[SR_Z] | status[SR_S];
      default: branch = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    done_d  = 1'b0;
    taken_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (op_q == OP_TRAP) begin
          epc_d   = pc_inc(pc_q);
          pc_d    = TRAP_VECTOR;
          taken_d = 1'b1;
          state_d = ST_TRAP;
        end else if (branch) begin
          pc_d    = operand_q;
          taken_d = 1'b1;
        end else begin
          pc_d    = pc_inc(pc_q);
        end
      end
      ST_TRAP: begin
        if (trap_clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      done_q  <= done_d;
      taken_q <= taken_d;
    end
  end

  assign sr_wr = (state_q == ST_EXEC) && ((op_q == OP_LDSR) || (op_q == OP_XORSR));

  status_reg u_status_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_valid (flag_valid),
    .flag_zero  (flag_zero),
    .flag_sign  (flag_sign),
    .flag_carry (flag_carry),
    .sr_wr      (sr_wr),
    .sr_xor     (op_q == OP_XORSR),
    .sr_val     (operand_q[SR_W-1:0]),
    .status     (status)
  );

  assign op_ready = (state_q == ST_IDLE);
  assign trapped  = (state_q == ST_TRAP);
  assign pc       = pc_q;
  assign epc      = epc_q;
  assign done     = done_q;
  assign taken    = taken_q;

endmodule

// File: tb/tb_flow_ctrl.sv
// tb_flow_ctrl: directed self-checking bench for flow_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_flow_ctrl;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [19:0] operand;
  logic        flag_valid;
  logic        flag_zero;
  logic        flag_sign;
  logic        flag_carry;
  logic        trap_clr;
  logic [19:0] pc;
  logic [2:0]  status;
  logic        done;
  logic        taken;
  logic        trapped;
  logic [19:0] epc;

  int checks = 0;
  int errors = 0;

  flow_ctrl #(
    .RESET_PC    (20'h00000),
    .TRAP_VECTOR (20'h00010)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .operand    (operand),
    .flag_valid (flag_valid),
    .flag_zero  (flag_zero),
    .flag_sign  (flag_sign),
    .flag_carry (flag_carry),
    .trap_clr   (trap_clr),
    .pc         (pc),
    .status     (status),
    .done       (done),
    .taken      (taken),
    .trapped    (trapped),
    .epc        (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers one op at a falling edge (DUT in IDLE), returns at the falling
  // edge after the retire edge. fl is {carry,sign,zero}. The operand is
  // scrambled during EXEC to show it is ignored there.
  task automatic run_op(input logic [2:0] o, input logic [19:0] opd,
                        input logic fv_acc, input logic fv_exec,
                        input logic [2:0] fl,
                        output logic exec_done, output logic exec_ready);
    op_valid   = 1'b1;
    op         = o;
    operand    = opd;
    flag_valid = fv_acc;
    {flag_carry, flag_sign, flag_zero} = fl;
    @(negedge clk);
    op_valid   = 1'b0;
    operand    = 20'h0F0F0;
    flag_valid = fv_exec;
    exec_done  = done;
    exec_ready = op_ready;
    @(negedge clk);
    flag_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 20'h00000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 20'h00000); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL reset_status got %b want %b", status, 3'b000); end
    checks++; if ({done, taken, trapped} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want %b", {done, taken, trapped}, 3'b000); end
    checks++; if (epc !== 20'h00000) begin errors++; $display("FAIL reset_epc got %h want %h", epc, 20'h00000); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want %b", op_ready, 1'b1); end
  endtask

  task automatic test_nop();
    logic ed, er;
    logic [19:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      exp_pc = 20'(i);
      run_op(3'd1, 20'h0AAAA, 1'b0, 1'b0, 3'b000, ed, er);
      checks++; if ({ed, er} !== 2'b00) begin errors++; $display("FAIL nop_exec_cycle got %b want %b", {ed, er}, 2'b00); end
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL nop_pc got %h want %h", pc, exp_pc); end
      checks++; if ({done, taken} !== 2'b10) begin errors++; $display("FAIL nop_done_taken got %b want %b", {done, taken}, 2'b10); end
    end
    // the done pulse lasts exactly one cycle
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL nop_done_pulse got %b want %b", done, 1'b0); end
  endtask

  task automatic test_branch();
    logic ed, er;
    // Z=1 arriving in the accept cycle -> JZ taken
    run_op(3'd3, 20'h00ABC, 1'b1, 1'b0, 3'b001, ed, er);
    checks++; if (pc !== 20'h00ABC) begin errors++; $display("FAIL jz_taken_pc got %h want %h", pc, 20'h00ABC); end
    checks++; if ({done, taken} !== 2'b11) begin errors++; $display("FAIL jz_taken_flag got %b want %b", {done, taken}, 2'b11); end
    // Z=0 -> not taken
    run_op(3'd3, 20'h00ABC, 1'b1, 1'b0, 3'b000, ed, er);
    checks++; if (pc !== 20'h00ABD) begin errors++; $display("FAIL jz_nt_pc got %h want %h", pc, 20'h00ABD); end
    checks++; if ({done, taken} !== 2'b10) begin errors++; $display("FAIL jz_nt_flag got %b want %b", {done, taken}, 2'b10); end
    // JZS with status 000 -> not taken
    run_op(3'd5, 20'h00200, 1'b0, 1'b0, 3'b000, ed, er);
    checks++; if (pc !== 20'h00ABE) begin errors++; $display("FAIL jzs_nt_pc got %h want %h", pc, 20'h00ABE); end
    // JMP always taken
    run_op(3'd2, 20'h00100, 1'b0, 1'b0, 3'b000, ed, er);
    checks++; if ({pc, taken} !== {20'h00100, 1'b1}) begin errors++; $display("FAIL jmp got %h/%b want %h/%b", pc, taken, 20'h00100, 1'b1); end
    // S=1 from flags -> JS taken
    run_op(3'd4, 20'h00040, 1'b1, 1'b0, 3'b010, ed, er);
    checks++; if ({pc, taken} !== {20'h00040, 1'b1}) begin errors++; $display("FAIL js got %h/%b want %h/%b", pc, taken, 20'h00040, 1'b1); end
    checks++; if (status !== 3'b010) begin errors++; $display("FAIL js_status got %b want %b", status, 3'b010); end
  endtask

  task automatic test_wrap();
    logic ed, er;
    run_op(3'd2, 20'hFFFFF, 1'b0, 1'b0, 3'b000, ed, er);
    checks++; if (pc !== 20'hFFFFF) begin errors++; $display("FAIL wrap_setup got %h want %h", pc, 20'hFFFFF); end
    run_op(3'd1, 20'h00000, 1'b0, 1'b0, 3'b000, ed, er);
    checks++; if ({pc, taken} !== {20'h00000, 1'b0}) begin errors++; $display("FAIL wrap_pc got %h/%b want %h/%b", pc, taken, 20'h00000, 1'b0); end
  endtask

  task automatic test_status_write();
    logic ed, er;
    // LDSR retiring with flag_valid {1,1,1}: LDSR wins
    run_op(3'd6, 20'h00005, 1'b0, 1'b1, 3'b111, ed, er);
    checks++; if (status !== 3'b101) begin errors++; $display("FAIL ldsr got %b want %b", status, 3'b101); end
    checks++; if (pc !== 20'h00001) begin errors++; $display("FAIL ldsr_pc got %h want %h", pc, 20'h00001); end
    run_op(3'd7, 20'h00003, 1'b0, 1'b0, 3'b000, ed, er);
    checks++; if (status !== 3'b110) begin errors++; $display("FAIL xorsr got %b want %b", status, 3'b110); end
    // status 110 has S set -> JZS taken
    run_op(3'd5, 20'h00077, 1'b0, 1'b0, 3'b000, ed, er);
    checks++; if ({pc, taken} !== {20'h00077, 1'b1}) begin errors++; $display("FAIL jzs_taken got %h/%b want %h/%b", pc, taken, 20'h00077, 1'b1); end
    // plain flag load {C=1,S=0,Z=1}
    flag_valid = 1'b1;
    {flag_carry, flag_sign, flag_zero} = 3'b101;
    @(negedge clk);
    flag_valid = 1'b0;
    checks++; if (status !== 3'b101) begin errors++; $display("FAIL flag_load got %b want %b", status, 3'b101); end
  endtask

  task automatic test_trap();
    logic ed, er;
    // trap_clr outside TRAP is ignored
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    checks++; if ({op_ready, trapped} !== 2'b10) begin errors++; $display("FAIL clr_idle got %b want %b", {op_ready, trapped}, 2'b10); end
    run_op(3'd2, 20'h00005, 1'b0, 1'b0, 3'b000, ed, er);
    run_op(3'd0, 20'h00999, 1'b0, 1'b0, 3'b000, ed, er);
    checks++; if (pc !== 20'h00010) begin errors++; $display("FAIL trap_pc got %h want %h", pc, 20'h00010); end
    checks++; if (epc !== 20'h00006) begin errors++; $display("FAIL trap_epc got %h want %h", epc, 20'h00006); end
    checks++; if ({done, taken, trapped, op_ready} !== 4'b1110) begin errors++; $display("FAIL trap_ctrl got %b want %b", {done, taken, trapped, op_ready}, 4'b1110); end
    // ops offered in TRAP are ignored; flags still land
    op_valid = 1'b1;
    op = 3'd1;
    flag_valid = 1'b1;
    {flag_carry, flag_sign, flag_zero} = 3'b011;
    @(negedge clk);
    flag_valid = 1'b0;
    checks++; if (status !== 3'b011) begin errors++; $display("FAIL trap_flags got %b want %b", status, 3'b011); end
    @(negedge clk);
    checks++; if ({pc, done, op_ready, trapped} !== {20'h00010, 3'b001}) begin errors++; $display("FAIL trap_hold got %h/%b want %h/%b", pc, {done, op_ready, trapped}, 20'h00010, 3'b001); end
    op_valid = 1'b0;
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    checks++; if ({pc, op_ready, trapped, done} !== {20'h00010, 3'b100}) begin errors++; $display("FAIL trap_clr got %h/%b want %h/%b", pc, {op_ready, trapped, done}, 20'h00010, 3'b100); end
  endtask

  task automatic test_reset_exec();
    op_valid = 1'b1;
    op = 3'd2;
    operand = 20'h12345;
    @(negedge clk);
    op_valid = 1'b0;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL rexec_in_exec got %b want %b", op_ready, 1'b0); end
    rst_n = 1'b0;
    #1;
    checks++; if ({pc, status, done} !== {20'h00000, 3'b000, 1'b0}) begin errors++; $display("FAIL rexec_async got %h/%b/%b want %h/%b/%b", pc, status, done, 20'h00000, 3'b000, 1'b0); end
    checks++; if (epc !== 20'h00000) begin errors++; $display("FAIL rexec_epc got %h want %h", epc, 20'h00000); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({pc, done, op_ready} !== {20'h00000, 2'b01}) begin errors++; $display("FAIL rexec_after got %h/%b want %h/%b", pc, {done, op_ready}, 20'h00000, 2'b01); end
  endtask

  initial begin
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    op         = 3'd1;
    operand    = 20'h00000;
    flag_valid = 1'b0;
    flag_zero  = 1'b0;
    flag_sign  = 1'b0;
    flag_carry = 1'b0;
    trap_clr   = 1'b0;
    test_reset();
    test_nop();
    test_branch();
    test_wrap();
    test_status_write();
    test_trap();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
